line_raster_engine: RTL and testbench
=====================================

LINE_RASTER_ENGINE -- requirements
Module: line_raster_engine

Interface
REQ-001 Parameters (name, default, meaning):
- SCR_W, 640, screen width in pixels.
- SCR_H, 480, screen height in pixels.
- XW, 10, x coordinate width.
- YW, 9, y coordinate width.
- CW, 3, colour width.
- CLEAR_EN, 1, 1 = clear screen on object change; 0 = skip clear.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cmd_data  in  2XW+2YW+CW+1  {x0,y0,x1,y1,color,valid}, valid at LSB.
- cmd_empty  in  1  command FIFO empty.
- cmd_rd_en  out  1  pop pulse; cmd_data valid the following cycle.
- frame_start  in  1  new frame may begin.
- end_of_objects  in  1  upstream has issued all commands.
- obj_change  in  1  scene changed; clear required.
- bk_color  in  CW  background colour.
- px_valid  out  1  pixel beat offered.
- px_ready  in  1  frame buffer accepts beat.
- px_x  out  XW  pixel x.
- px_y  out  YW  pixel y.
- px_color  out  CW  pixel colour.
- px_clr  out  1  beat is a clear-pass pixel.
- raster_done  out  1  one-cycle frame-complete pulse.
- busy  out  1  state != IDLE.

Function
REQ-004 States: IDLE, CLEAR, FETCH, LOAD, DRAW.
REQ-005 IDLE transitions:
- frame_start&obj_change with CLEAR_EN=1 -> zero the scan counters, go to CLEAR.
- frame_start&obj_change with CLEAR_EN=0 -> go to FETCH.
- Otherwise stay in IDLE.
REQ-006 CLEAR:
- px_valid=1, px_clr=1, px_color=bk_color; px_x/px_y come from scan counters in raster order.
- x wraps at SCR_W-1 and increments y; each beat (px_valid&px_ready) advances the counters.
- Accepted beat at (SCR_W-1,SCR_H-1) -> FETCH.
REQ-007 FETCH:
- cmd_empty&end_of_objects&frame_start -> raster_done pulse; then CLEAR (zero counters) if obj_change&CLEAR_EN, else IDLE.
- Otherwise ~cmd_empty -> cmd_rd_en=1, go to LOAD.
- Otherwise stay in FETCH.
REQ-008 LOAD:
- Samples cmd_data.
- valid=0 -> discard, go to FETCH (no beats).
- valid=1 -> latch endpoints and colour, initialise Bresenham state, go to DRAW.
REQ-009 Bresenham setup:
- dx=|x1-x0|, dy=-|y1-y0|, sx=sign(x1-x0), sy=sign(y1-y0).
- err=dx+dy, held in a signed register of max(XW,YW)+2 bits.
REQ-010 Bresenham step, taken on each accepted DRAW beat that is not the final point:
- e2=2*err.
- If e2>=dy: err+=dy, x+=sx.
- If e2<=dx: err+=dx, y+=sy.
- Both updates use the pre-step err; all octants are supported.
REQ-011 DRAW:
- px_valid=1 and px_clr=0 when the current point is on-screen (x<SCR_W, y<SCR_H); px_color=latched colour.
- An off-screen point is not offered: px_valid=0 and the step advances without waiting for px_ready.
REQ-012 A line emits exactly max(dx,|dy|)+1 points including both endpoints. After the point equal to (x1,y1) is accepted or skipped, go to FETCH.
REQ-013 While px_valid=1 and px_ready=0, px_x, px_y, px_color and px_clr hold stable and no counter or Bresenham state changes.
REQ-014 px_valid does not depend combinationally on px_ready.
REQ-015 cmd_rd_en is asserted only in FETCH, for exactly one cycle per pop, and never when cmd_empty=1.
REQ-016 obj_change and frame_start are ignored in CLEAR, LOAD and DRAW.
REQ-017 busy=0 only in IDLE.

Reset
REQ-018 rst=1 at a clock edge forces IDLE on that edge.
REQ-019 While rst=1, every output is 0: px_valid, px_x, px_y, px_color, px_clr, cmd_rd_en, raster_done, busy.
REQ-020 rst=1 at a clock edge zeroes scan counters, Bresenham registers and latched command.
REQ-021 A reset mid-CLEAR or mid-DRAW abandons the operation; no further beats until a new IDLE trigger.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- SCR_W=4, SCR_H=2, px_ready=1, obj_change+frame_start -> 8 clear beats (0,0)..(3,1) in raster order with bk_color, then FETCH.
- Valid line (0,0)->(3,0), color=5 -> beats (0,0),(1,0),(2,0),(3,0) color 5, px_clr=0.
- Line (2,5)->(0,0) -> 6 beats, first (2,5), last (0,0), each step |dx|<=1, |dy|=1.
- Line (5,5)->(5,5) -> single beat (5,5); invalid command (valid=0) -> popped, zero beats.
- px_ready low 3 cycles mid-line -> outputs frozen 3 cycles, sequence unchanged.
- cmd_empty&end_of_objects&frame_start&obj_change in FETCH -> one raster_done pulse, straight into CLEAR; rst mid-DRAW -> px_valid=0 next cycle, state IDLE.

Source files
------------

// File: rtl/line_raster_engine.sv
// Line rasteriser: optional background clear pass, then Bresenham lines popped from
// a command FIFO and streamed out as valid/ready pixel beats.
module line_raster_engine #(
  parameter int unsigned SCR_W    = 640,
  parameter int unsigned SCR_H    = 480,
  parameter int unsigned XW       = 10,
  parameter int unsigned YW       = 9,
  parameter int unsigned CW       = 3,
  parameter bit          CLEAR_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*XW+2*YW+CW:0]   cmd_data,
  input  logic                    cmd_empty,
  output logic                    cmd_rd_en,
  input  logic                    frame_start,
  input  logic                    end_of_objects,
  input  logic                    obj_change,
  input  logic [CW-1:0]           bk_color,
  output logic                    px_valid,
  input  logic                    px_ready,
  output logic [XW-1:0]           px_x,
  output logic [YW-1:0]           px_y,
  output logic [CW-1:0]           px_color,
  output logic                    px_clr,
  output logic                    raster_done,
  output logic                    busy
);

  localparam int unsigned EW = ((XW > YW) ? XW : YW) + 2;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FETCH, S_LOAD, S_DRAW} state_t;

  typedef struct packed {
    logic [XW-1:0] x0;
    logic [YW-1:0] y0;
    logic [XW-1:0] x1;
    logic [YW-1:0] y1;
    logic [CW-1:0] color;
    logic          valid;
  } cmd_t;

  cmd_t cmd;
  assign cmd = cmd_t'(cmd_data);

  state_t               state_q, state_d;
  logic [XW-1:0]        scan_x_q, scan_x_d, cur_x_q, cur_x_d, end_x_q, end_x_d;
  logic [YW-1:0]        scan_y_q, scan_y_d, cur_y_q, cur_y_d, end_y_q, end_y_d;
  logic [CW-1:0]        col_q, col_d;
  logic                 x_dec_q, x_dec_d, y_dec_q, y_dec_d;
  logic signed [EW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;

  logic                 valid_w, clr_w, rd_w, done_w;

  // Bresenham setup from the command currently presented on cmd_data
  logic [XW-1:0]        adx;
  logic [YW-1:0]        ady;
  logic signed [EW-1:0] dx_init, dy_init;
  assign adx     = (cmd.x1 >= cmd.x0) ? (cmd.x1 - cmd.x0) : (cmd.x0 - cmd.x1);
  assign ady     = (cmd.y1 >= cmd.y0) ? (cmd.y1 - cmd.y0) : (cmd.y0 - cmd.y1);
  assign dx_init = $signed(EW'(adx));
  assign dy_init = -$signed(EW'(ady));

  // e2 carries one extra bit so 2*err never overflows
  logic signed [EW:0]   e2, dx_ext, dy_ext;
  logic                 step_x, step_y, on_screen, at_end, scan_x_last, scan_y_last;
  assign e2          = $signed({err_q, 1'b0});
  assign dx_ext      = $signed({dx_q[EW-1], dx_q});
  assign dy_ext      = $signed({dy_q[EW-1], dy_q});
  assign step_x      = (e2 >= dy_ext);
  assign step_y      = (e2 <= dx_ext);
  assign on_screen   = (32'(cur_x_q) < SCR_W) && (32'(cur_y_q) < SCR_H);
  assign at_end      = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);
  assign scan_x_last = (32'(scan_x_q) == SCR_W - 1);
  assign scan_y_last = (32'(scan_y_q) == SCR_H - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      scan_x_q <= '0;
      scan_y_q <= '0;
      cur_x_q  <= '0;
      cur_y_q  <= '0;
      end_x_q  <= '0;
      end_y_q  <= '0;
      col_q    <= '0;
      x_dec_q  <= 1'b0;
      y_dec_q  <= 1'b0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      scan_x_q <= scan_x_d;
      scan_y_q <= scan_y_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      end_x_q  <= end_x_d;
      end_y_q  <= end_y_d;
      col_q    <= col_d;
      x_dec_q  <= x_dec_d;
      y_dec_q  <= y_dec_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    scan_x_d = scan_x_q;
    scan_y_d = scan_y_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    end_x_d  = end_x_q;
    end_y_d  = end_y_q;
    col_d    = col_q;
    x_dec_d  = x_dec_q;
    y_dec_d  = y_dec_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    valid_w  = 1'b0;
    clr_w    = 1'b0;
    rd_w     = 1'b0;
    done_w   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_start && obj_change) begin
          if (CLEAR_EN) begin
            scan_x_d = '0;
            scan_y_d = '0;
            state_d  = S_CLEAR;
          end else begin
            state_d  = S_FETCH;
          end
        end
      end

      S_CLEAR: begin
        valid_w = 1'b1;
        clr_w   = 1'b1;
        if (px_ready) begin
          if (scan_x_last) begin
            scan_x_d = '0;
            if (scan_y_last) begin
              scan_y_d = '0;
              state_d  = S_FETCH;
            end else begin
              scan_y_d = scan_y_q + YW'(1);
            end
          end else begin
            scan_x_d = scan_x_q + XW'(1);
          end
        end
      end

      S_FETCH: begin
        if (cmd_empty && end_of_objects && frame_start) begin
          done_w = 1'b1;
          if (obj_change && CLEAR_EN) begin
            scan_x_d = '0;
            scan_y_d = '0;
            state_d  = S_CLEAR;
          end else begin
            state_d  = S_IDLE;
          end
        end else if (!cmd_empty) begin
          rd_w    = 1'b1;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        if (cmd.valid) begin
          cur_x_d = cmd.x0;
          cur_y_d = cmd.y0;
          end_x_d = cmd.x1;
          end_y_d = cmd.y1;
          col_d   = cmd.color;
          x_dec_d = (cmd.x1 < cmd.x0);
          y_dec_d = (cmd.y1 < cmd.y0);
          dx_d    = dx_init;
          dy_d    = dy_init;
          err_d   = dx_init + dy_init;
          state_d = S_DRAW;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_DRAW: begin
        valid_w = on_screen;
        // Off-screen points are skipped without waiting on the frame buffer
        if (!on_screen || px_ready) begin
          if (at_end) begin
            state_d = S_FETCH;
          end else begin
            if (step_x) begin
              err_d   = err_d + dy_q;
              cur_x_d = x_dec_q ? (cur_x_q - XW'(1)) : (cur_x_q + XW'(1));
            end
            if (step_y) begin
              err_d   = err_d + dx_q;
              cur_y_d = y_dec_q ? (cur_y_q - YW'(1)) : (cur_y_q + YW'(1));
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are forced low for the whole time reset is held
  assign px_valid    = !rst && valid_w;
  assign px_clr      = !rst && clr_w;
  assign px_x        = px_valid ? (clr_w ? scan_x_q : cur_x_q) : '0;
  assign px_y        = px_valid ? (clr_w ? scan_y_q : cur_y_q) : '0;
  assign px_color    = px_valid ? (clr_w ? bk_color : col_q) : '0;
  assign cmd_rd_en   = !rst && rd_w;
  assign raster_done = !rst && done_w;
  assign busy        = !rst && (state_q != S_IDLE);

endmodule

// File: tb/tb_line_raster_engine.sv
// Directed bench: a 4x2 screen with clear enabled and an 8x8 screen without clear,
// fed from a modelled command FIFO; one instance is active at a time.
module tb_line_raster_engine;

  localparam int unsigned XW   = 10;
  localparam int unsigned YW   = 9;
  localparam int unsigned CW   = 3;
  localparam int unsigned CMDW = 2*XW + 2*YW + CW + 1;
  localparam int unsigned PW   = XW + YW + CW + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, sel, frame_start, obj_change, end_of_objects, cmd_empty, px_ready;
  logic [CMDW-1:0] cmd_data;
  logic [CW-1:0]   bk_color;
  logic            fs_a, fs_b, emp_a, emp_b;

  assign fs_a  = frame_start & ~sel;
  assign fs_b  = frame_start & sel;
  assign emp_a = cmd_empty | sel;
  assign emp_b = cmd_empty | ~sel;

  logic          a_rd, a_valid, a_clr, a_done, a_busy;
  logic          b_rd, b_valid, b_clr, b_done, b_busy;
  logic [XW-1:0] a_x, b_x;
  logic [YW-1:0] a_y, b_y;
  logic [CW-1:0] a_col, b_col;

  line_raster_engine #(.SCR_W(4), .SCR_H(2), .XW(XW), .YW(YW), .CW(CW), .CLEAR_EN(1'b1)) u_a (
    .clk(clk), .rst(rst), .cmd_data(cmd_data), .cmd_empty(emp_a), .cmd_rd_en(a_rd),
    .frame_start(fs_a), .end_of_objects(end_of_objects), .obj_change(obj_change),
    .bk_color(bk_color), .px_valid(a_valid), .px_ready(px_ready), .px_x(a_x), .px_y(a_y),
    .px_color(a_col), .px_clr(a_clr), .raster_done(a_done), .busy(a_busy));

  line_raster_engine #(.SCR_W(8), .SCR_H(8), .XW(XW), .YW(YW), .CW(CW), .CLEAR_EN(1'b0)) u_b (
    .clk(clk), .rst(rst), .cmd_data(cmd_data), .cmd_empty(emp_b), .cmd_rd_en(b_rd),
    .frame_start(fs_b), .end_of_objects(end_of_objects), .obj_change(obj_change),
    .bk_color(bk_color), .px_valid(b_valid), .px_ready(px_ready), .px_x(b_x), .px_y(b_y),
    .px_color(b_col), .px_clr(b_clr), .raster_done(b_done), .busy(b_busy));

  logic          m_rd, m_valid, m_clr, m_done, m_busy, m_empty;
  logic [PW-1:0] m_pix;
  assign m_rd    = sel ? b_rd    : a_rd;
  assign m_valid = sel ? b_valid : a_valid;
  assign m_clr   = sel ? b_clr   : a_clr;
  assign m_done  = sel ? b_done  : a_done;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_empty = sel ? emp_b   : emp_a;
  assign m_pix   = sel ? {b_x, b_y, b_col, b_clr} : {a_x, a_y, a_col, a_clr};

  int              checks = 0;
  int              failures = 0;
  int              n_pops = 0;
  int              n_done = 0;
  int              base;
  logic            got;
  logic [PW-1:0]   beats[$];
  logic [CMDW-1:0] fifo[$];
  logic            s_valid, s_clr, s_done, s_busy;
  logic [PW-1:0]   s_pix;

  int ex[9] = '{2, 2, 1, 1, 0, 0, 5, 6, 7};
  int ey[9] = '{5, 4, 3, 2, 1, 0, 5, 0, 0};
  int ec[9] = '{7, 7, 7, 7, 7, 7, 1, 4, 4};

  function automatic logic [PW-1:0] pk(input int x, input int y, input int c, input int k);
    return {XW'(x), YW'(y), CW'(c), 1'(k)};
  endfunction

  function automatic logic [CMDW-1:0] mk(input int x0, input int y0, input int x1,
                                         input int y1, input int c, input int v);
    return {XW'(x0), YW'(y0), XW'(x1), YW'(y1), CW'(c), 1'(v)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, log accepted beats, serve FIFO pops after the edge
  task automatic step();
    logic pop;
    pop = 1'b0;
    @(negedge clk);
    s_valid = m_valid;
    s_clr   = m_clr;
    s_done  = m_done;
    s_busy  = m_busy;
    s_pix   = m_pix;
    if (m_valid && px_ready) beats.push_back(m_pix);
    if (m_done) n_done++;
    if (m_rd) begin
      chk("rd_while_empty", 64'(m_empty), 64'd0);
      pop = 1'b1;
      n_pops++;
    end
    @(posedge clk);
    #1;
    if (pop && fifo.size() > 0) begin
      cmd_data  = fifo.pop_front();
      cmd_empty = (fifo.size() == 0);
    end
  endtask

  task automatic wait_beats(input int target, input int max_cyc, input string tag);
    int n;
    n = 0;
    while (beats.size() < target && n < max_cyc) begin
      step();
      n++;
    end
    chk(tag, 64'(beats.size() >= target), 64'd1);
  endtask

  task automatic push(input logic [CMDW-1:0] c);
    fifo.push_back(c);
    cmd_empty = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sel = 1'b0; frame_start = 1'b0; obj_change = 1'b0; end_of_objects = 1'b0;
    cmd_empty = 1'b1; px_ready = 1'b1; cmd_data = '0; bk_color = 3'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs_a", 64'({a_valid, a_x, a_y, a_col, a_clr, a_rd, a_done, a_busy}), 64'd0);
    chk("reset_outs_b", 64'({b_valid, b_x, b_y, b_col, b_clr, b_rd, b_done, b_busy}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("idle_after_reset", 64'({s_valid, s_busy}), 64'd0);

    // Clear pass then a horizontal line and an invalid command
    push(mk(0, 0, 3, 0, 5, 1));
    push(mk(1, 1, 2, 1, 6, 0));
    frame_start = 1'b1; obj_change = 1'b1;
    step();
    frame_start = 1'b0; obj_change = 1'b0;
    wait_beats(12, 40, "s1_timeout");
    repeat (4) step();
    chk("s1_beat_count", 64'(beats.size()), 64'd12);
    for (int i = 0; i < 8; i++) chk("clear_beat", 64'(beats[i]), 64'(pk(i % 4, i / 4, 2, 1)));
    for (int i = 0; i < 4; i++) chk("hline_beat", 64'(beats[8 + i]), 64'(pk(i, 0, 5, 0)));
    chk("s1_pops", 64'(n_pops), 64'd2);
    chk("s1_fetch_wait", 64'({s_busy, s_valid}), 64'b10);

    // Back-pressure for three cycles in the middle of a line
    base = beats.size();
    push(mk(0, 1, 3, 1, 3, 1));
    wait_beats(base + 2, 20, "s2_pre_timeout");
    px_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold", 64'({s_valid, s_pix}), 64'({1'b1, pk(2, 1, 3, 0)}));
    end
    px_ready = 1'b1;
    wait_beats(base + 4, 10, "s2_post_timeout");
    for (int i = 0; i < 4; i++) chk("stall_seq", 64'(beats[base + i]), 64'(pk(i, 1, 3, 0)));
    repeat (2) step();
    chk("s2_count", 64'(beats.size()), 64'(base + 4));

    // End of frame with a scene change: done pulse, then straight into a clear
    end_of_objects = 1'b1; frame_start = 1'b1; obj_change = 1'b1; bk_color = 3'd6;
    base = beats.size();
    step();
    chk("raster_done_pulse", 64'(s_done), 64'd1);
    frame_start = 1'b0; obj_change = 1'b0; end_of_objects = 1'b0;
    step();
    chk("clear_restart", 64'({s_done, s_valid, s_pix}), 64'({1'b0, 1'b1, pk(0, 0, 6, 1)}));
    wait_beats(base + 8, 12, "s3_timeout");
    chk("s3_last_clear", 64'(beats[base + 7]), 64'(pk(3, 1, 6, 1)));
    repeat (2) step();
    chk("s3_done_count", 64'(n_done), 64'd1);

    // Reset in the middle of a line
    push(mk(0, 0, 3, 0, 1, 1));
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      got = s_valid & ~s_clr;
    end
    chk("s4_draw_seen", 64'(got), 64'd1);
    rst = 1'b1;
    base = beats.size();
    step();
    chk("rst_mid_draw", 64'({s_valid, s_busy}), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_idle", 64'({s_valid, s_busy}), 64'd0);
    end
    chk("s4_no_beats", 64'(beats.size()), 64'(base));

    // Larger screen, no clear: steep reverse line, single point, partly off-screen line
    sel = 1'b1;
    base = beats.size();
    push(mk(2, 5, 0, 0, 7, 1));
    push(mk(5, 5, 5, 5, 1, 1));
    push(mk(6, 0, 9, 0, 4, 1));
    frame_start = 1'b1; obj_change = 1'b1;
    step();
    frame_start = 1'b0; obj_change = 1'b0;
    wait_beats(base + 9, 60, "b_timeout");
    repeat (3) step();
    chk("b_count", 64'(beats.size()), 64'(base + 9));
    for (int i = 0; i < 9; i++) chk("b_beat", 64'(beats[base + i]), 64'(pk(ex[i], ey[i], ec[i], 0)));
    chk("total_pops", 64'(n_pops), 64'd7);
    end_of_objects = 1'b1; frame_start = 1'b1; obj_change = 1'b1;
    step();
    chk("b_done", 64'(s_done), 64'd1);
    frame_start = 1'b0; obj_change = 1'b0; end_of_objects = 1'b0;
    step();
    chk("b_idle", 64'({s_busy, s_valid}), 64'd0);
    chk("done_count", 64'(n_done), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
